// File: rtl/cp0_pkg.sv
// Shared CP0 definitions used by the CP0 register file and the exception
// sequencer: exception cause codes, Status bit positions and the sequencer
// FSM state encoding.
package cp0_pkg;

    // Status bit positions
    localparam int CP0_ST_IE         = 0;  // global interrupt enable
    localparam int CP0_ST_SYSCALL_EN = 1;
    localparam int CP0_ST_BREAK_EN   = 2;
    localparam int CP0_ST_TEQ_EN     = 3;
    localparam int CP0_IRQ_MASK_BASE = 8;  // irqN mask sits at this bit + N

    // Cause codes
    localparam logic [4:0] CP0_CAUSE_IRQ     = 5'd0;
    localparam logic [4:0] CP0_CAUSE_SYSCALL = 5'd8;
    localparam logic [4:0] CP0_CAUSE_BREAK   = 5'd9;
    localparam logic [4:0] CP0_CAUSE_TEQ     = 5'd13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ENTER  = 2'd2,
        ST_SHADOW = 2'd3
    } exc_state_t;

endpackage

// File: rtl/irq_pend.sv
// External interrupt pending tracker.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   irq_i        external requests (synchronous to clk), edge-sensitive
//   ack_i        one-hot acknowledge; clears the matching pending bit
//   en_i         per-line enable (global IE already folded in)
//   pending_o    pending vector
//   any_o        at least one pending line is enabled
//   idx_o        lowest enabled pending index (valid when any_o)
module irq_pend #(
    parameter int NIRQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_i,
    input  logic [NIRQ-1:0] ack_i,
    input  logic [NIRQ-1:0] en_i,
    output logic [NIRQ-1:0] pending_o,
    output logic            any_o,
    output logic [IDW-1:0]  idx_o
);

    logic [NIRQ-1:0] irq_prev;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] cand;

    // A fresh edge wins over a same-cycle acknowledge of that line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_i;
            pending  <= (pending & ~ack_i) | (irq_i & ~irq_prev);
        end
    end

    assign pending_o = pending;

    // Scan from the top down so the lowest enabled index is the last write.
    always_comb begin
        cand  = pending & en_i;
        any_o = |cand;
        idx_o = '0;
        for (int n = NIRQ - 1; n >= 0; n--) begin
            if (cand[n]) idx_o = IDW'(n);
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / interrupt sequencer in front of CP0.
// Synchronous traps (syscall > break > teq) and eret are answered in the
// same cycle they commit. External interrupts wait in IDLE until selected,
// stall the PC in DRAIN while the multiply/divide unit finishes, are taken
// for one cycle in ENTER, and every entry/return is followed by a one-cycle
// SHADOW in which nothing new is accepted while Status settles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid              current instruction commits
//   syscall_i/break_i/teq_i  decoded trap instructions (teq: condition true)
//   eret_i                   decoded eret
//   mdu_busy                 multiply/divide unit mid-operation
//   irq_i                    external interrupt requests
//   status_i                 CP0 Status
//   exception_o/eret_o/cause_o  to CP0
//   irq_id_o, irq_ack_o      index and one-hot ack of the interrupt taken
//   pc_stall_o               hold PC, suppress writes
//   irq_pending_o            pending interrupt vector
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter int         NIRQ          = 4,
    parameter int         IRQ_MASK_BASE = CP0_IRQ_MASK_BASE,
    parameter logic [4:0] CAUSE_SYSCALL = CP0_CAUSE_SYSCALL,
    parameter logic [4:0] CAUSE_BREAK   = CP0_CAUSE_BREAK,
    parameter logic [4:0] CAUSE_TEQ     = CP0_CAUSE_TEQ,
    parameter logic [4:0] CAUSE_IRQ     = CP0_CAUSE_IRQ,
    localparam int        IDW           = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic            syscall_i,
    input  logic            break_i,
    input  logic            teq_i,
    input  logic            eret_i,
    input  logic            mdu_busy,
    input  logic [NIRQ-1:0] irq_i,
    input  logic [31:0]     status_i,
    output logic            exception_o,
    output logic            eret_o,
    output logic [4:0]      cause_o,
    output logic [IDW-1:0]  irq_id_o,
    output logic [NIRQ-1:0] irq_ack_o,
    output logic            pc_stall_o,
    output logic [NIRQ-1:0] irq_pending_o
);

    exc_state_t      state, state_nxt;
    logic [NIRQ-1:0] irq_en;
    logic            irq_any;
    logic [IDW-1:0]  irq_idx;
    logic            sys_take, brk_take, teq_take;
    logic            status_unused;

    assign status_unused = ^status_i;

    always_comb begin
        for (int n = 0; n < NIRQ; n++) begin
            irq_en[n] = status_i[CP0_ST_IE] & status_i[IRQ_MASK_BASE + n];
        end
    end

    assign sys_take = instr_valid & syscall_i & status_i[CP0_ST_SYSCALL_EN];
    assign brk_take = instr_valid & break_i   & status_i[CP0_ST_BREAK_EN];
    assign teq_take = instr_valid & teq_i     & status_i[CP0_ST_TEQ_EN];

    irq_pend #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) u_irq_pend (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (irq_i),
        .ack_i     (irq_ack_o),
        .en_i      (irq_en),
        .pending_o (irq_pending_o),
        .any_o     (irq_any),
        .idx_o     (irq_idx)
    );

    // Outputs are decoded from state and current inputs because CP0 must see
    // traps in the cycle the instruction commits. Reset forces them low.
    always_comb begin
        state_nxt   = state;
        exception_o = 1'b0;
        eret_o      = 1'b0;
        cause_o     = '0;
        irq_id_o    = '0;
        irq_ack_o   = '0;
        pc_stall_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sys_take | brk_take | teq_take) begin
                    exception_o = 1'b1;
                    cause_o     = sys_take ? CAUSE_SYSCALL :
                                  brk_take ? CAUSE_BREAK : CAUSE_TEQ;
                    state_nxt   = ST_SHADOW;
                end else if (instr_valid & eret_i) begin
                    eret_o    = 1'b1;
                    state_nxt = ST_SHADOW;
                end else if (irq_any) begin
                    state_nxt = mdu_busy ? ST_DRAIN : ST_ENTER;
                end
            end
            ST_DRAIN: begin
                // Losing the enable mid-drain abandons the entry at once.
                if (!irq_any) begin
                    state_nxt = ST_IDLE;
                end else begin
                    pc_stall_o = 1'b1;
                    if (!mdu_busy) state_nxt = ST_ENTER;
                end
            end
            ST_ENTER: begin
                if (irq_any) begin
                    exception_o        = 1'b1;
                    cause_o            = CAUSE_IRQ;
                    irq_id_o           = irq_idx;
                    irq_ack_o[irq_idx] = 1'b1;
                    state_nxt          = ST_SHADOW;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHADOW: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            exception_o = 1'b0;
            eret_o      = 1'b0;
            cause_o     = '0;
            irq_id_o    = '0;
            irq_ack_o   = '0;
            pc_stall_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

endmodule
